// File: rtl/l2_home_if.sv
// Packed two-client L1.5 <-> L2 message bus, plus the shared field widths and message/MESI encodings.
// Client k occupies slice [k*W +: W] of every bus.
`ifndef L2_HOME_DEFS
`define L2_HOME_DEFS
`define MSG_WIDTH        4
`define TAG_WIDTH        4
`define DATA_WIDTH       8
`define MESI_WIDTH       2
`define MSG_EMPTY        4'd0
`define MSG_LOAD_REQ     4'd1
`define MSG_STORE_REQ    4'd2
`define MSG_WB_REQ       4'd3
`define MSG_DATA_ACK     4'd4
`define MSG_NODATA_ACK   4'd5
`define MSG_INV_FWD      4'd6
`define MSG_LOAD_FWD     4'd7
`define MSG_STORE_FWD    4'd8
`define MSG_INV_FWDACK   4'd9
`define MSG_LOAD_FWDACK  4'd10
`define MSG_STORE_FWDACK 4'd11
`define MESI_I           2'd0
`define MESI_S           2'd1
`define MESI_E           2'd2
`define MESI_M           2'd3
`endif

interface l2_home_if;
    logic [2*`MSG_WIDTH-1:0]  msg1_type;
    logic [2*`TAG_WIDTH-1:0]  msg1_tag;
    logic [2*`DATA_WIDTH-1:0] msg1_data;
    logic [2*`MSG_WIDTH-1:0]  msg3_type;
    logic [2*`DATA_WIDTH-1:0] msg3_data;
    logic [2*`MSG_WIDTH-1:0]  msg2_type;
    logic [2*`TAG_WIDTH-1:0]  msg2_tag;
    logic [2*`DATA_WIDTH-1:0] msg2_data;
    logic [2*`MESI_WIDTH-1:0] mesi_send;

    modport slave (
        input  msg1_type, msg1_tag, msg1_data, msg3_type, msg3_data,
        output msg2_type, msg2_tag, msg2_data, mesi_send
    );

    modport master (
        output msg1_type, msg1_tag, msg1_data, msg3_type, msg3_data,
        input  msg2_type, msg2_tag, msg2_data, mesi_send
    );
endinterface

// File: rtl/l2_home.sv
// L2 home node with full-map directory for two L1.5 clients; serialises one transaction at a time.
// Optional L2_EXCL_GRANT_EN: a load to an uncached line is granted MESI_E instead of MESI_S.
module l2_home #(
    parameter int MEM_DEPTH = (1 << `TAG_WIDTH),
    parameter bit RR_INIT   = 1'b0
) (
    input  logic     clk,
    input  logic     rst,
    l2_home_if.slave bus_io
);
    localparam int MW = `MSG_WIDTH;
    localparam int TW = `TAG_WIDTH;
    localparam int DW = `DATA_WIDTH;
    localparam int EW = `MESI_WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WB, ST_GRANT, ST_FWD_SEND, ST_FWD_WAIT, ST_FWD_ACK, ST_HOLD
    } state_e;

    typedef enum logic [1:0] {DIR_I, DIR_S, DIR_EXCL} dir_e;

    function automatic logic [1:0] oneHot(input logic k);
        return k ? 2'b10 : 2'b01;
    endfunction

    state_e          state_q, state_d, holdNext_q, holdNext_d;
    logic            rr_q, rr_d;
    logic            reqK_q, reqK_d, reqStore_q, reqStore_d;
    logic [TW-1:0]   reqTag_q, reqTag_d;
    logic [DW-1:0]   reqData_q, reqData_d;
    logic [MW-1:0]   fwdMsg_q, fwdMsg_d, fwdAck_q, fwdAck_d;

    logic [DW-1:0]   mem_q   [MEM_DEPTH];
    dir_e            dirSt_q [MEM_DEPTH];
    logic [1:0]      sh_q    [MEM_DEPTH];
    logic [TW-1:0]   curTag_q [2];
    logic [1:0]      curVld_q;

    logic [2*MW-1:0] msg2Type_q;
    logic [2*TW-1:0] msg2Tag_q;
    logic [2*DW-1:0] msg2Data_q;
    logic [2*EW-1:0] mesi_q;
    logic [MW-1:0]   msg2Type_d [2];
    logic [TW-1:0]   msg2Tag_d  [2];
    logic [DW-1:0]   msg2Data_d [2];
    logic [EW-1:0]   mesi_d     [2];

    logic            memWe, dirWe, curWe, curK, curVldWr;
    logic [TW-1:0]   memAddr, dirAddr, curTagWr;
    logic [DW-1:0]   memWdata;
    dir_e            dirStWr;
    logic [1:0]      shWr;

    logic            selK, selStore, kOther;
    logic [TW-1:0]   selTag, evictTag;
    dir_e            selSt;
    logic [1:0]      selSh;

    logic [MW-1:0]   m1Type [2];
    logic [TW-1:0]   m1Tag  [2];
    logic [DW-1:0]   m1Data [2];
    logic [MW-1:0]   m3Type [2];
    logic [DW-1:0]   m3Data [2];

    for (genvar g = 0; g < 2; g++) begin : g_unpack
        assign m1Type[g] = bus_io.msg1_type[g*MW +: MW];
        assign m1Tag[g]  = bus_io.msg1_tag[g*TW +: TW];
        assign m1Data[g] = bus_io.msg1_data[g*DW +: DW];
        assign m3Type[g] = bus_io.msg3_type[g*MW +: MW];
        assign m3Data[g] = bus_io.msg3_data[g*DW +: DW];
    end

    assign bus_io.msg2_type = msg2Type_q;
    assign bus_io.msg2_tag  = msg2Tag_q;
    assign bus_io.msg2_data = msg2Data_q;
    assign bus_io.mesi_send = mesi_q;

    // Next state, next outputs, and at most one memory / directory / per-client write per cycle.
    always_comb begin
        state_d    = state_q;
        holdNext_d = holdNext_q;
        rr_d       = rr_q;
        reqK_d     = reqK_q;
        reqTag_d   = reqTag_q;
        reqStore_d = reqStore_q;
        reqData_d  = reqData_q;
        fwdMsg_d   = fwdMsg_q;
        fwdAck_d   = fwdAck_q;
        for (int k = 0; k < 2; k++) begin
            msg2Type_d[k] = `MSG_EMPTY;
            msg2Tag_d[k]  = '0;
            msg2Data_d[k] = '0;
            mesi_d[k]     = `MESI_I;
        end
        memWe    = 1'b0;
        memAddr  = reqTag_q;
        memWdata = reqData_q;
        dirWe    = 1'b0;
        dirAddr  = reqTag_q;
        dirStWr  = DIR_I;
        shWr     = 2'b00;
        curWe    = 1'b0;
        curK     = reqK_q;
        curTagWr = reqTag_q;
        curVldWr = 1'b0;
        selK     = rr_q;
        selTag   = '0;
        selStore = 1'b0;
        selSt    = DIR_I;
        selSh    = 2'b00;
        evictTag = '0;
        kOther   = ~reqK_q;

        case (state_q)
            ST_IDLE: begin
                if (m3Type[0] == `MSG_WB_REQ || m3Type[1] == `MSG_WB_REQ) begin
                    reqK_d  = (m3Type[0] != `MSG_WB_REQ);
                    state_d = ST_WB;
                end else if (m1Type[0] != `MSG_EMPTY || m1Type[1] != `MSG_EMPTY) begin
                    if (m1Type[0] == `MSG_EMPTY) begin
                        selK = 1'b1;
                    end else if (m1Type[1] == `MSG_EMPTY) begin
                        selK = 1'b0;
                    end
                    selTag     = m1Tag[selK];
                    selStore   = (m1Type[selK] == `MSG_STORE_REQ);
                    selSt      = dirSt_q[selTag];
                    selSh      = sh_q[selTag];
                    reqK_d     = selK;
                    reqTag_d   = selTag;
                    reqStore_d = selStore;
                    reqData_d  = m1Data[selK];
                    // Requester moved to a new line: silently drop it from the old entry.
                    evictTag   = curTag_q[selK];
                    if (curVld_q[selK] && evictTag != selTag) begin
                        dirWe   = 1'b1;
                        dirAddr = evictTag;
                        shWr    = sh_q[evictTag] & ~oneHot(selK);
                        dirStWr = (shWr == 2'b00) ? DIR_I : dirSt_q[evictTag];
                    end
                    if (selSh[~selK] && selSt == DIR_EXCL) begin
                        fwdMsg_d = selStore ? `MSG_STORE_FWD : `MSG_LOAD_FWD;
                        fwdAck_d = selStore ? `MSG_STORE_FWDACK : `MSG_LOAD_FWDACK;
                        state_d  = ST_FWD_SEND;
                    end else if (selSh[~selK] && selSt == DIR_S && selStore) begin
                        fwdMsg_d = `MSG_INV_FWD;
                        fwdAck_d = `MSG_INV_FWDACK;
                        state_d  = ST_FWD_SEND;
                    end else begin
                        state_d  = ST_GRANT;
                    end
                end
            end
            ST_WB: begin
                memWe              = 1'b1;
                memAddr            = curTag_q[reqK_q];
                memWdata           = m3Data[reqK_q];
                dirWe              = 1'b1;
                dirAddr            = curTag_q[reqK_q];
                dirStWr            = DIR_I;
                shWr               = sh_q[curTag_q[reqK_q]] & ~oneHot(reqK_q);
                curWe              = 1'b1;
                curTagWr           = curTag_q[reqK_q];
                curVldWr           = 1'b0;
                msg2Type_d[reqK_q] = `MSG_NODATA_ACK;
                holdNext_d         = ST_IDLE;
                state_d            = ST_HOLD;
            end
            ST_FWD_SEND: begin
                msg2Type_d[kOther] = fwdMsg_q;
                state_d            = ST_FWD_WAIT;
            end
            ST_FWD_WAIT: begin
                if (m3Type[kOther] == fwdAck_q) begin
                    state_d = ST_FWD_ACK;
                end
            end
            ST_FWD_ACK: begin
                dirWe    = 1'b1;
                memWdata = m3Data[kOther];
                if (fwdMsg_q == `MSG_LOAD_FWD) begin
                    memWe   = 1'b1;
                    dirStWr = DIR_S;
                    shWr    = oneHot(kOther);
                end else if (fwdMsg_q == `MSG_STORE_FWD) begin
                    memWe   = 1'b1;
                    dirStWr = DIR_I;
                    shWr    = 2'b00;
                end else begin
                    shWr    = sh_q[reqTag_q] & ~oneHot(kOther);
                    dirStWr = (shWr == 2'b00) ? DIR_I : DIR_S;
                end
                msg2Type_d[kOther] = `MSG_NODATA_ACK;
                holdNext_d         = ST_GRANT;
                state_d            = ST_HOLD;
            end
            ST_GRANT: begin
                msg2Type_d[reqK_q] = `MSG_DATA_ACK;
                msg2Tag_d[reqK_q]  = reqTag_q;
                dirWe              = 1'b1;
                curWe              = 1'b1;
                curVldWr           = 1'b1;
                rr_d               = ~rr_q;
                holdNext_d         = ST_IDLE;
                state_d            = ST_HOLD;
                if (reqStore_q) begin
                    memWe              = 1'b1;
                    msg2Data_d[reqK_q] = reqData_q;
                    mesi_d[reqK_q]     = `MESI_M;
                    dirStWr            = DIR_EXCL;
                    shWr               = oneHot(reqK_q);
                end else if (dirSt_q[reqTag_q] == DIR_S) begin
                    msg2Data_d[reqK_q] = mem_q[reqTag_q];
                    mesi_d[reqK_q]     = `MESI_S;
                    dirStWr            = DIR_S;
                    shWr               = sh_q[reqTag_q] | oneHot(reqK_q);
                end else begin
                    msg2Data_d[reqK_q] = mem_q[reqTag_q];
                    shWr               = oneHot(reqK_q);
`ifdef L2_EXCL_GRANT_EN
                    mesi_d[reqK_q]     = `MESI_E;
                    dirStWr            = DIR_EXCL;
`else
                    mesi_d[reqK_q]     = `MESI_S;
                    dirStWr            = DIR_S;
`endif
                end
            end
            ST_HOLD: begin
                state_d = holdNext_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, directory, backing store and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            holdNext_q  <= ST_IDLE;
            rr_q        <= RR_INIT;
            reqK_q      <= 1'b0;
            reqTag_q    <= '0;
            reqStore_q  <= 1'b0;
            reqData_q   <= '0;
            fwdMsg_q    <= `MSG_EMPTY;
            fwdAck_q    <= `MSG_EMPTY;
            curTag_q[0] <= '0;
            curTag_q[1] <= '0;
            curVld_q    <= 2'b00;
            msg2Type_q  <= '0;
            msg2Tag_q   <= '0;
            msg2Data_q  <= '0;
            mesi_q      <= '0;
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i]   <= '0;
                dirSt_q[i] <= DIR_I;
                sh_q[i]    <= 2'b00;
            end
        end else begin
            state_q    <= state_d;
            holdNext_q <= holdNext_d;
            rr_q       <= rr_d;
            reqK_q     <= reqK_d;
            reqTag_q   <= reqTag_d;
            reqStore_q <= reqStore_d;
            reqData_q  <= reqData_d;
            fwdMsg_q   <= fwdMsg_d;
            fwdAck_q   <= fwdAck_d;
            msg2Type_q <= {msg2Type_d[1], msg2Type_d[0]};
            msg2Tag_q  <= {msg2Tag_d[1], msg2Tag_d[0]};
            msg2Data_q <= {msg2Data_d[1], msg2Data_d[0]};
            mesi_q     <= {mesi_d[1], mesi_d[0]};
            if (memWe) begin
                mem_q[memAddr] <= memWdata;
            end
            if (dirWe) begin
                dirSt_q[dirAddr] <= dirStWr;
                sh_q[dirAddr]    <= shWr;
            end
            if (curWe) begin
                curTag_q[curK] <= curTagWr;
                curVld_q[curK] <= curVldWr;
            end
        end
    end
endmodule
